// File: rtl/shifter_pkg.sv
// Shared constants and helpers for the pipelined barrel shifter.
// Mode 2'b11 is a logical right shift only when SHIFTER_SRL_EN is defined.
package shifter_pkg;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRA = 2'b01;
  localparam logic [1:0] MODE_ROR = 2'b10;
  localparam logic [1:0] MODE_SRL = 2'b11;

  // Stage 1 resolves shamt bits [SHAMT_W-1:H]; stage 2 resolves [H-1:0].
  function automatic int split_point(input int shamt_w);
    return shamt_w / 2;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shifter slice: shifts by amt_i * 2**BASE in the selected mode.
// Optional SRL support for mode 2'b11 is compiled in with SHIFTER_SRL_EN.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 2,
  parameter int BASE  = 0
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [1:0]       mode_i,
  output logic [WIDTH-1:0] data_o
);

  localparam int SH_W = AMT_W + BASE;

  logic [SH_W-1:0] sh;

  assign sh = SH_W'(amt_i) << BASE;

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    data_o = '0;
    case (mode_i)
      MODE_SLL: data_o = data_i << sh;
      MODE_SRA: data_o = $signed(data_i) >>> sh;
      // A left shift by WIDTH yields zero, so sh == 0 still rotates correctly.
      MODE_ROR: data_o = (data_i >> sh) | (data_i << (WIDTH - sh));
`ifdef SHIFTER_SRL_EN
      MODE_SRL: data_o = data_i >> sh;
`endif
      default:  data_o = '0;
    endcase
  end

endmodule

// File: rtl/pipe_shifter.sv
// Two-stage pipelined barrel shifter with valid/ready handshakes and a pass-through tag.
// Define SHIFTER_SRL_EN to make mode 2'b11 a logical right shift; otherwise it yields zero.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_zero,
  output logic               out_neg
);

  localparam int H    = split_point(SHAMT_W);
  localparam int HI_W = SHAMT_W - H;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_data_q, s1_data_d;
  logic [H-1:0]       s1_shamt_q;
  logic [1:0]         s1_mode_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q;
  logic [TAG_W-1:0]   out_tag_q;
  logic               out_zero_q, out_neg_q;

  logic [WIDTH-1:0]   s2_result;
  logic               s1_adv, s2_adv, s2_load;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv && rst_n;
  assign s2_load  = s2_adv && s1_valid_q;

  shift_stage #(.WIDTH(WIDTH), .AMT_W(HI_W), .BASE(H)) u_stage1 (
    .data_i (in_data),
    .amt_i  (in_shamt[SHAMT_W-1:H]),
    .mode_i (in_mode),
    .data_o (s1_data_d)
  );

  shift_stage #(.WIDTH(WIDTH), .AMT_W(H), .BASE(0)) u_stage2 (
    .data_i (s1_data_q),
    .amt_i  (s1_shamt_q),
    .mode_i (s1_mode_q),
    .data_o (s2_result)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d  = in_valid;
      if (s2_adv) out_valid_d = s1_valid_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        out_data_q <= s2_result;
        out_tag_q  <= s1_tag_q;
        out_zero_q <= (s2_result == '0);
        out_neg_q  <= s2_result[WIDTH-1];
      end
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (s1_adv) begin
      s1_data_q  <= s1_data_d;
      s1_shamt_q <= in_shamt[H-1:0];
      s1_mode_q  <= in_mode;
      s1_tag_q   <= in_tag;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;

endmodule
